// File: rtl/tdm_demux_4ch_if.sv
// Bundle of serial-side inputs and demultiplexed outputs for tdm_demux_4ch.
// The master drives the serial line; the slave is the demultiplexer.
interface tdm_demux_4ch_if #(
  parameter int unsigned DATA_W = 8
);
  logic              din;
  logic              din_valid;
  logic              sync;
  logic              o0;
  logic              o1;
  logic              o2;
  logic              o3;
  logic [DATA_W-1:0] y0;
  logic [DATA_W-1:0] y1;
  logic [DATA_W-1:0] y2;
  logic [DATA_W-1:0] y3;
  logic              out_valid;
  logic              sync_err;
  logic              locked;

  modport master (
    output din, din_valid, sync,
    input  o0, o1, o2, o3, y0, y1, y2, y3, out_valid, sync_err, locked
  );

  modport slave (
    input  din, din_valid, sync,
    output o0, o1, o2, o3, y0, y1, y2, y3, out_valid, sync_err, locked
  );
endinterface

// File: rtl/tdm_demux_4ch.sv
// Four-channel TDM demultiplexer: aligns to frame sync, routes each valid bit
// to its slot and assembles MSB-first DATA_W-bit words per channel.
module tdm_demux_4ch #(
  parameter int unsigned DATA_W = 8
) (
  input logic            clk,
  input logic            rst,
  tdm_demux_4ch_if.slave bus
);
  localparam int unsigned FrameW = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [FrameW-1:0] LastFrame = FrameW'(DATA_W - 1);

  typedef enum logic [0:0] {StHunt, StLock} state_e;

  state_e            r_state_q,     w_state_d;
  logic [1:0]        r_slot_cnt_q,  w_slot_cnt_d;
  logic [FrameW-1:0] r_frame_cnt_q, w_frame_cnt_d;
  logic [DATA_W-1:0] r_sh_q [4];
  logic [DATA_W-1:0] w_sh_d [4];
  logic [DATA_W-1:0] r_y_q  [4];
  logic [DATA_W-1:0] w_y_d  [4];
  logic [3:0]        r_o_q,         w_o_d;
  logic              r_out_valid_q, w_out_valid_d;
  logic              r_sync_err_q,  w_sync_err_d;
  logic              w_realign;
  logic              w_shift;

  always_comb begin
    w_state_d     = r_state_q;
    w_slot_cnt_d  = r_slot_cnt_q;
    w_frame_cnt_d = r_frame_cnt_q;
    w_sh_d        = r_sh_q;
    w_y_d         = r_y_q;
    w_o_d         = r_o_q;
    w_out_valid_d = 1'b0;
    w_sync_err_d  = 1'b0;
    w_realign     = 1'b0;
    w_shift       = 1'b0;

    unique case (r_state_q)
      StHunt: begin
        if (bus.din_valid && bus.sync) w_realign = 1'b1;
      end
      StLock: begin
        if (bus.din_valid) begin
          // A sync landing at slot 0 is simply a normal bit on a frame boundary.
          if (bus.sync && (r_slot_cnt_q != 2'd0)) begin
            w_realign    = 1'b1;
            w_sync_err_d = 1'b1;
          end else begin
            w_shift = 1'b1;
          end
        end
      end
      default: w_state_d = StHunt;
    endcase

    if (w_realign) begin
      for (int k = 0; k < 4; k++) w_sh_d[k] = '0;
      w_sh_d[0]     = DATA_W'(bus.din);
      w_o_d[0]      = bus.din;
      w_slot_cnt_d  = 2'd1;
      w_frame_cnt_d = '0;
      w_state_d     = StLock;
    end

    if (w_shift) begin
      for (int k = 0; k < 4; k++) begin
        if (r_slot_cnt_q == 2'(k)) begin
          w_sh_d[k] = {r_sh_q[k][DATA_W-2:0], bus.din};
          w_o_d[k]  = bus.din;
        end
      end
      w_slot_cnt_d = r_slot_cnt_q + 2'd1;
      if (r_slot_cnt_q == 2'd3) begin
        if (r_frame_cnt_q == LastFrame) begin
          // Final bit of slot 3 is already merged into w_sh_d[3] above.
          w_y_d         = w_sh_d;
          w_out_valid_d = 1'b1;
          w_frame_cnt_d = '0;
        end else begin
          w_frame_cnt_d = r_frame_cnt_q + FrameW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state_q     <= StHunt;
      r_slot_cnt_q  <= '0;
      r_frame_cnt_q <= '0;
      r_sh_q        <= '{default: '0};
      r_y_q         <= '{default: '0};
      r_o_q         <= '0;
      r_out_valid_q <= 1'b0;
      r_sync_err_q  <= 1'b0;
    end else begin
      r_state_q     <= w_state_d;
      r_slot_cnt_q  <= w_slot_cnt_d;
      r_frame_cnt_q <= w_frame_cnt_d;
      r_sh_q        <= w_sh_d;
      r_y_q         <= w_y_d;
      r_o_q         <= w_o_d;
      r_out_valid_q <= w_out_valid_d;
      r_sync_err_q  <= w_sync_err_d;
    end
  end

  assign bus.o0        = r_o_q[0];
  assign bus.o1        = r_o_q[1];
  assign bus.o2        = r_o_q[2];
  assign bus.o3        = r_o_q[3];
  assign bus.y0        = r_y_q[0];
  assign bus.y1        = r_y_q[1];
  assign bus.y2        = r_y_q[2];
  assign bus.y3        = r_y_q[3];
  assign bus.out_valid = r_out_valid_q;
  assign bus.sync_err  = r_sync_err_q;
  assign bus.locked    = (r_state_q == StLock);
endmodule

// File: tb/tb_tdm_demux_4ch.sv
// Directed bench for tdm_demux_4ch at DATA_W=4: table-driven full frame plus
// hand-written gap, live-demux, misaligned-sync and reset-mid-frame sequences.
module tb_tdm_demux_4ch;
  localparam int unsigned W = 4;

  logic clk = 1'b0;
  logic rst;

  tdm_demux_4ch_if #(.DATA_W(W)) bus ();

  tdm_demux_4ch #(.DATA_W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       din;
    logic       sync;
    logic [3:0] exp_o;   // {o3,o2,o1,o0}
    logic       exp_ov;
  } vec_t;

  vec_t tbl [16];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] o_vec();
    return {bus.o3, bus.o2, bus.o1, bus.o0};
  endfunction

  function automatic logic [15:0] y_vec();
    return {bus.y3, bus.y2, bus.y1, bus.y0};
  endfunction

  // ws = {y3,y2,y1,y0}; bit idx goes to slot idx%4, frame idx/4, MSB first
  function automatic logic wbit(input logic [15:0] ws, input int idx);
    logic [3:0] w;
    w = ws[(idx % 4) * 4 +: 4];
    return w[3 - (idx / 4)];
  endfunction

  task automatic step(input logic v, input logic s, input logic d);
    bus.din_valid = v;
    bus.sync      = s;
    bus.din       = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_o"}, 32'(o_vec()), 32'h0);
    chk({tag, "_y"}, 32'(y_vec()), 32'h0);
    chk({tag, "_ov_err_lock"}, 32'({bus.out_valid, bus.sync_err, bus.locked}), 32'h0);
  endtask

  // Asserts rst between clock edges and checks outputs before any edge.
  task automatic apply_reset();
    #2;
    rst           = 1'b1;
    bus.din_valid = 1'b0;
    bus.sync      = 1'b0;
    bus.din       = 1'b0;
    #1;
    check_zero("rst_async");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic send_words(input logic [15:0] ws, input bit gaps, input int first);
    for (int i = first; i < 16; i++) begin
      if (gaps) begin
        int ng;
        ng = int'($urandom_range(0, 2));
        if (i == 7) ng = 1;
        for (int g = 0; g < ng; g++) begin
          logic [3:0] o_before;
          o_before = o_vec();
          step(1'b0, 1'b1, 1'($urandom_range(0, 1)));
          chk("gap_hold_o", 32'(o_vec()), 32'(o_before));
          chk("gap_no_ov", 32'(bus.out_valid), 32'h0);
          chk("gap_sync_ignored", 32'(bus.sync_err), 32'h0);
        end
      end
      step(1'b1, 1'(i == 0), wbit(ws, i));
      chk("no_sync_err", 32'(bus.sync_err), 32'h0);
      chk("locked", 32'(bus.locked), 32'h1);
      if (i < 15) begin
        chk("no_early_ov", 32'(bus.out_valid), 32'h0);
      end else begin
        chk("ov_pulse", 32'(bus.out_valid), 32'h1);
        chk("y_words", 32'(y_vec()), 32'(ws));
      end
    end
    step(1'b0, 1'b0, 1'b0);
    chk("ov_one_cycle", 32'(bus.out_valid), 32'h0);
    chk("y_hold", 32'(y_vec()), 32'(ws));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // y0=A, y1=5, y2=F, y3=0 interleaved MSB first
    tbl[0]  = '{1'b1, 1'b1, 4'b0001, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 4'b0001, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 4'b0101, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 4'b0101, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 4'b0100, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 4'b0110, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 4'b0110, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 4'b0110, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 4'b0111, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 4'b0101, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 4'b0101, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 4'b0101, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 4'b0100, 1'b0};
    tbl[13] = '{1'b1, 1'b0, 4'b0110, 1'b0};
    tbl[14] = '{1'b1, 1'b0, 4'b0110, 1'b0};
    tbl[15] = '{1'b0, 1'b0, 4'b0110, 1'b1};

    rst           = 1'b1;
    bus.din       = 1'b0;
    bus.din_valid = 1'b0;
    bus.sync      = 1'b0;
    #12;
    check_zero("rst_init");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Full frame, continuous valid
    for (int i = 0; i < 16; i++) begin
      step(1'b1, tbl[i].sync, tbl[i].din);
      chk("tbl_o", 32'(o_vec()), 32'(tbl[i].exp_o));
      chk("tbl_ov", 32'(bus.out_valid), 32'(tbl[i].exp_ov));
      chk("tbl_locked", 32'(bus.locked), 32'h1);
      chk("tbl_err", 32'(bus.sync_err), 32'h0);
      if (tbl[i].exp_ov) chk("tbl_y", 32'(y_vec()), 32'h0F5A);
    end
    step(1'b0, 1'b0, 1'b0);
    chk("tbl_ov_single", 32'(bus.out_valid), 32'h0);
    chk("tbl_y_hold", 32'(y_vec()), 32'h0F5A);

    // Reset from a non-zero state, then same words with valid gaps
    apply_reset();
    send_words(16'h0F5A, 1'b1, 0);

    // Live demux: each o_k moves only on its own slot
    apply_reset();
    step(1'b1, 1'b1, 1'b0);
    chk("live_s0", 32'(o_vec()), 32'h0);
    step(1'b0, 1'b0, 1'b1);
    chk("live_gap", 32'(o_vec()), 32'h0);
    step(1'b1, 1'b0, 1'b1);
    chk("live_s1", 32'(o_vec()), 32'b0010);
    step(1'b1, 1'b0, 1'b0);
    chk("live_s2", 32'(o_vec()), 32'b0010);
    step(1'b1, 1'b0, 1'b1);
    chk("live_s3", 32'(o_vec()), 32'b1010);
    step(1'b1, 1'b0, 1'b1);
    chk("live_s0_again", 32'(o_vec()), 32'b1011);

    // Misaligned sync at slot 2 of frame 1
    apply_reset();
    step(1'b1, 1'b1, 1'b1);
    for (int i = 1; i < 6; i++) begin
      step(1'b1, 1'b0, 1'b1);
      chk("pre_no_err", 32'(bus.sync_err), 32'h0);
    end
    step(1'b1, 1'b1, wbit(16'h69C3, 0));
    chk("mis_err", 32'(bus.sync_err), 32'h1);
    chk("mis_no_ov", 32'(bus.out_valid), 32'h0);
    chk("mis_locked", 32'(bus.locked), 32'h1);
    chk("mis_y_hold", 32'(y_vec()), 32'h0);
    chk("mis_o0", 32'(bus.o0), 32'(wbit(16'h69C3, 0)));
    send_words(16'h69C3, 1'b0, 1);

    // Reset mid-frame, then unsynced bits are discarded
    apply_reset();
    step(1'b1, 1'b1, 1'b1);
    for (int i = 1; i < 7; i++) step(1'b1, 1'b0, 1'(i % 2));
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 1'((i + 1) % 2));
      check_zero("hunt_discard");
    end
    send_words(16'h1E2D, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
